// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue unit and its FPU-side interface.
package fpu_pkg;

    typedef enum logic [2:0] {
        FN_FADD  = 3'd0,
        FN_FSUB  = 3'd1,
        FN_FMUL  = 3'd2,
        FN_FDIV  = 3'd3,
        FN_FMIN  = 3'd4,
        FN_FMAX  = 3'd5,
        FN_FSQRT = 3'd6,
        FN_FCVT  = 3'd7
    } fpu_funct_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fpu_state_t;

    localparam logic [31:0] FPU_ONE  = 32'h3f800000;
    localparam logic [31:0] FPU_QNAN = 32'h7fc00000;

endpackage

// File: rtl/IFpu.sv
// Connection between the issue unit (master) and the floating-point datapath (slave).
interface IFpu;
    import fpu_pkg::*;

    logic        en;
    fpu_funct_t  funct;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] result;
    logic        stall;

    modport master (output en, funct, val1, val2, input result, stall);
    modport slave  (input en, funct, val1, val2, output result, stall);
endinterface

// File: rtl/fpu_issue_unit.sv
// Single-entry issue stage: latches one FPU request, pulses it into the FPU and holds the result.
// Optional WAIT-state stall timeout is built when FPU_TIMEOUT_EN is defined.
import fpu_pkg::*;

module fpu_issue_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  fpu_funct_t  req_funct,
    input  logic [31:0] req_val1,
    input  logic [31:0] req_val2,
    input  logic [5:0]  req_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [5:0]  resp_tag,
    output logic        busy,
    output logic        timeout_err,
    IFpu.master         fpu
);

    fpu_state_t  r_state;
    fpu_funct_t  r_funct;
    logic [31:0] r_val1;
    logic [31:0] r_val2;
    logic [5:0]  r_tag;
    logic [31:0] r_result;
    logic        w_accept;
    logic        w_capture;
    logic        w_timeout_hit;

    // Accepting in IDLE needs a quiet FPU, which also covers one left busy by a reset.
    assign req_ready = ((r_state == IDLE) && !fpu.stall) || ((r_state == DONE) && resp_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_capture = (r_state == WAIT) && !fpu.stall;

`ifdef FPU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;

    assign w_timeout_hit = (r_state == WAIT) && fpu.stall &&
                           (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err   = r_timeout;

    // Count consecutive stalled cycles while waiting for a result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == WAIT) && fpu.stall && !w_timeout_hit) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end else begin
            r_timeout <= r_timeout;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout_hit    = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // Control state machine
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= w_accept ? ISSUE : IDLE;
                ISSUE:   r_state <= fpu.stall ? ISSUE : WAIT;
                WAIT:    r_state <= (w_capture || w_timeout_hit) ? DONE : WAIT;
                DONE: begin
                    if (!resp_ready) begin
                        r_state <= DONE;
                    end else if (req_valid) begin
                        r_state <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Request latch; these values also drive the FPU operands in every state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_funct <= FN_FADD;
            r_val1  <= FPU_ONE;
            r_val2  <= FPU_ONE;
            r_tag   <= 6'd0;
        end else if (w_accept) begin
            r_funct <= req_funct;
            r_val1  <= req_val1;
            r_val2  <= req_val2;
            r_tag   <= req_tag;
        end else begin
            r_funct <= r_funct;
            r_val1  <= r_val1;
            r_val2  <= r_val2;
            r_tag   <= r_tag;
        end
    end

    // Result capture: FPU result, or quiet NaN when the wait timed out
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result <= 32'h0000_0000;
        end else if (w_capture) begin
            r_result <= fpu.result;
        end else if (w_timeout_hit) begin
            r_result <= FPU_QNAN;
        end else begin
            r_result <= r_result;
        end
    end

    assign fpu.en      = (r_state == ISSUE) && !fpu.stall;
    assign fpu.funct   = r_funct;
    assign fpu.val1    = r_val1;
    assign fpu.val2    = r_val2;

    assign resp_valid  = (r_state == DONE);
    assign resp_result = r_result;
    assign resp_tag    = r_tag;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Self-checking bench for fpu_issue_unit with a behavioural FPU stub of programmable latency.
module tb_fpu_issue_unit;
    import fpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    fpu_funct_t  req_funct = FN_FADD;
    logic [31:0] req_val1 = 32'h0;
    logic [31:0] req_val2 = 32'h0;
    logic [5:0]  req_tag = 6'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic [5:0]  resp_tag;
    logic        busy;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    IFpu fpu_if();

    fpu_issue_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_val1(req_val1), .req_val2(req_val2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag),
        .busy(busy), .timeout_err(timeout_err), .fpu(fpu_if)
    );

    // Behavioural FPU arithmetic: real add for FADD, a fixed bit mix otherwise.
    function automatic real sp_to_real(input logic [31:0] a);
        logic [10:0] e;
        e = {3'b000, a[30:23]} + 11'd896;
        return $bitstoreal({a[31], e, a[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] stub_calc(input fpu_funct_t f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        if (f == FN_FADD) begin
            d = $realtobits(sp_to_real(a) + sp_to_real(b));
            e = d[62:52] - 11'd896;
            return {d[63], e[7:0], d[51:29]};
        end
        return a ^ {b[15:0], b[31:16]} ^ {29'd0, 3'(f)};
    endfunction

    int          stub_lat = 1;
    int          stub_cnt = 0;
    logic [31:0] stub_res = 32'h0;
    logic        force_stall = 1'b0;
    int          en_pulses = 0;
    int          en_stall_bad = 0;

    assign fpu_if.stall  = force_stall | (stub_cnt != 0);
    assign fpu_if.result = stub_res;

    always @(posedge clock) begin
        if (fpu_if.en) begin
            stub_cnt <= stub_lat - 1;
            stub_res <= stub_calc(fpu_if.funct, fpu_if.val1, fpu_if.val2);
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
        if (fpu_if.en) en_pulses <= en_pulses + 1;
        if (fpu_if.en && fpu_if.stall) en_stall_bad <= en_stall_bad + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_resp(input string name, input int limit, output int k);
        k = 0;
        while (!resp_valid && k < limit) begin
            @(negedge clock);
            k++;
        end
        check({name, "_resp_in_time"}, (k < limit) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // One full transaction: present, wait for acceptance, measure latency, hold, release.
    task automatic run_op(input string name, input fpu_funct_t f, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] t, input int lat, input int hold,
                          input logic [31:0] exp_res, input int exp_k);
        int          guard;
        int          k;
        int          en_seen;
        logic        bad;
        logic [31:0] held_res;
        logic [5:0]  held_tag;
        @(negedge clock);
        stub_lat = lat; req_valid = 1'b1; req_funct = f; req_val1 = a; req_val2 = b; req_tag = t;
        resp_ready = 1'b0;
        #1;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clock); #1; guard++;
        end
        check({name, "_accept"}, (guard < 200) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        check({name, "_issue_en"}, fpu_if.en, 1);
        check({name, "_issue_val1"}, fpu_if.val1, a);
        check({name, "_issue_val2"}, fpu_if.val2, b);
        en_seen = 1;
        k = 0;
        while (!resp_valid && k < 200) begin
            @(negedge clock);
            k++;
            if (fpu_if.en) en_seen++;
        end
        check({name, "_latency"}, k, exp_k);
        check({name, "_en_once"}, en_seen, 1);
        check({name, "_result"}, resp_result, exp_res);
        check({name, "_tag"}, resp_tag, t);
        held_res = resp_result; held_tag = resp_tag; bad = 1'b0;
        repeat (hold) begin
            @(negedge clock);
            if (!resp_valid || resp_result !== held_res || resp_tag !== held_tag || fpu_if.en || req_ready)
                bad = 1'b1;
        end
        if (hold > 0) check({name, "_backpressure_stable"}, bad, 0);
        @(negedge clock);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check({name, "_released"}, {busy, resp_valid}, 2'b00);
    endtask

    typedef struct {
        fpu_funct_t  funct;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [5:0]  tag;
        int          lat;
        int          hold;
        logic [31:0] exp_res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    initial begin
        int          k;
        logic        bad;
        logic        pend;
        int          acc;
        int          en_start;
        exp_t        e;

        vecs[0] = '{FN_FADD, 32'h3f800000, 32'h40000000, 6'd17, 3, 0, 32'h40400000};
        vecs[1] = '{FN_FADD, 32'h40000000, 32'h40000000, 6'd63, 1, 5, 32'h40800000};
        vecs[2] = '{FN_FADD, 32'h3fc00000, 32'h3f000000, 6'd0,  2, 0, 32'h40000000};
        vecs[3] = '{FN_FADD, 32'h40400000, 32'h40800000, 6'd42, 5, 2, 32'h40e00000};
        vecs[4] = '{FN_FADD, 32'h3e800000, 32'h3e800000, 6'd5,  4, 1, 32'h3f000000};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_en", fpu_if.en, 0);
        check("rst_val1", fpu_if.val1, 32'h3f800000);
        check("rst_val2", fpu_if.val2, 32'h3f800000);
        check("rst_funct", fpu_if.funct, 0);
        check("rst_result", resp_result, 0);
        check("rst_tag", resp_tag, 0);
        reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);

        // Table-driven single operations
        for (int i = 0; i < 5; i++)
            run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].v1, vecs[i].v2, vecs[i].tag,
                   vecs[i].lat, vecs[i].hold, vecs[i].exp_res, vecs[i].lat + 1);

        // Back-to-back: second request in the DONE/resp_ready cycle
        @(negedge clock);
        stub_lat = 2; req_valid = 1'b1; req_funct = FN_FADD;
        req_val1 = 32'h3f800000; req_val2 = 32'h3f800000; req_tag = 6'd9; resp_ready = 1'b0;
        #1;
        check("b2b_a_ready", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        wait_resp("b2b_a", 50, k);
        check("b2b_a_result", resp_result, 32'h40000000);
        resp_ready = 1'b1; req_valid = 1'b1; req_funct = FN_FMUL;
        req_val1 = 32'h12345678; req_val2 = 32'h9abcdef0; req_tag = 6'd33;
        #1;
        check("b2b_same_cycle_accept", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0; resp_ready = 1'b0;
        check("b2b_en", fpu_if.en, 1);
        check("b2b_resp_dropped", resp_valid, 0);
        check("b2b_val1", fpu_if.val1, 32'h12345678);
        @(negedge clock);
        check("b2b_en_single", fpu_if.en, 0);
        wait_resp("b2b_b", 50, k);
        check("b2b_b_result", resp_result, stub_calc(FN_FMUL, 32'h12345678, 32'h9abcdef0));
        check("b2b_b_tag", resp_tag, 6'd33);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;

        // FPU stall held across reset exit
        force_stall = 1'b1; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; stub_lat = 1; req_valid = 1'b1; req_funct = FN_FSUB;
        req_val1 = 32'hcafef00d; req_val2 = 32'h0badbeef; req_tag = 6'd12;
        bad = 1'b0;
        repeat (10) begin
            #1;
            if (req_ready || fpu_if.en || busy) bad = 1'b1;
            @(negedge clock);
        end
        check("stall_exit_hold", bad, 0);
        force_stall = 1'b0;
        #1;
        check("stall_exit_ready", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        check("stall_exit_en", fpu_if.en, 1);
        wait_resp("stall_exit", 50, k);
        check("stall_exit_result", resp_result, stub_calc(FN_FSUB, 32'hcafef00d, 32'h0badbeef));
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;

        // Reset asserted mid-WAIT
        stub_lat = 20; req_valid = 1'b1; req_funct = FN_FDIV;
        req_val1 = 32'h11111111; req_val2 = 32'h22222222; req_tag = 6'd50;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_wait_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", fpu_if.en, 0);
        check("mid_rst_val1", fpu_if.val1, 32'h3f800000);
        check("mid_rst_funct", fpu_if.funct, 0);
        check("mid_rst_tag", resp_tag, 0);
        check("mid_rst_result", resp_result, 0);
        check("mid_rst_req_ready", req_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        bad = 1'b0;
        repeat (25) begin
            @(negedge clock);
            if (resp_valid || fpu_if.en) bad = 1'b1;
        end
        check("mid_rst_no_resp", bad, 0);

`ifdef FPU_TIMEOUT_EN
        // Stall outlasts the 16-cycle budget
        run_op("timeout", FN_FMAX, 32'h00000001, 32'h00000002, 6'd21, 40, 0, 32'h7fc00000, 17);
        check("timeout_err_set", timeout_err, 1);
        repeat (45) @(negedge clock);
        check("timeout_err_sticky", timeout_err, 1);
        reset = 1'b1;
        #1;
        check("timeout_err_cleared", timeout_err, 0);
        @(negedge clock);
        reset = 1'b0;
`else
        // Without the timeout a long stall simply waits
        run_op("long_wait", FN_FMAX, 32'h00000001, 32'h00000002, 6'd21, 40, 0,
               stub_calc(FN_FMAX, 32'h00000001, 32'h00000002), 41);
        check("no_timeout_err", timeout_err, 0);
`endif

        // Randomized traffic against a scoreboard of expected results in order
        repeat (50) @(negedge clock);
        en_start = en_pulses;
        pend = 1'b0; acc = 0;
        for (int cyc = 0; cyc < 1560; cyc++) begin
            @(negedge clock);
            if (cyc >= 1500) begin
                pend = 1'b0;
                resp_ready = 1'b1;
            end else begin
                if (!pend && $urandom_range(3, 0) != 0) begin
                    pend = 1'b1;
                    req_funct = fpu_funct_t'($urandom_range(7, 1));
                    req_val1 = $urandom; req_val2 = $urandom; req_tag = 6'($urandom);
                end
                resp_ready = ($urandom_range(2, 0) != 0);
                stub_lat = $urandom_range(4, 1);
            end
            req_valid = pend;
            #1;
            if (resp_valid && resp_ready) begin
                check("rand_resp_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rand_result", resp_result, e.res);
                    check("rand_tag", resp_tag, e.tag);
                end
            end
            if (pend && req_ready) begin
                sb.push_back('{stub_calc(req_funct, req_val1, req_val2), req_tag});
                pend = 1'b0;
                acc++;
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        check("rand_drained", sb.size(), 0);
        check("rand_en_per_accept", en_pulses - en_start, acc);
        check("en_never_with_stall", en_stall_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
